// File: rtl/fork4_pkg.sv
// fork4_pkg: shared state encoding and default sizing for the 4-way fork controller.
package fork4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } fork4_state_e;

  localparam int N_OUT_DEF = 4;

  typedef logic [N_OUT_DEF-1:0] fork4_mask_t;

endpackage

// File: rtl/fork4_sat_ctr.sv
// fork4_sat_ctr: saturating event counter, cleared only by reset.
module fork4_sat_ctr
  import fork4_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count events and stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fork4_ctrl.sv
// fork4_ctrl: eager 1-to-N broadcast fork. A token is delivered to every
// output selected by its mask; each output retires independently and a new
// token can be taken in the same cycle the last pending output accepts.
// Optional performance counters are built when FORK4_PERF_EN is defined.
module fork4_ctrl
  import fork4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = N_OUT_DEF,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OUT-1:0]       dest_mask,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   busy,
  output logic                   drop
`ifdef FORK4_PERF_EN
  ,
  output logic [N_OUT*CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]       tok_cnt
`endif
);

  fork4_state_e     r_state, w_state_nx;
  logic [WIDTH-1:0] r_hold, w_hold_nx;
  logic [N_OUT-1:0] r_pending, w_pending_nx, w_left;
  logic             r_en, r_drop, w_drop_nx;
  logic             w_retire, w_hs;

  // Outputs still owed after this cycle's acceptances; none left means retire.
  assign w_left   = r_pending & ~out_ready;
  assign w_retire = (w_left == '0);
  // Combinational from out_ready so a retiring token makes room the same cycle.
  assign in_ready = r_en & ((r_state == IDLE) | w_retire);
  assign w_hs     = in_valid & in_ready;

  // One-cycle enable delay so nothing is accepted on the release edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_en <= 1'b0;
    else        r_en <= 1'b1;
  end

  // State and token registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_pending <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_hold    <= w_hold_nx;
      r_pending <= w_pending_nx;
      r_drop    <= w_drop_nx;
    end
  end

  // Next state: capture on handshake (empty mask drops), else clear accepted outputs.
  always_comb begin
    w_state_nx   = r_state;
    w_hold_nx    = r_hold;
    w_pending_nx = w_left;
    w_drop_nx    = 1'b0;
    if (w_hs) begin
      w_hold_nx    = in_data;
      w_pending_nx = dest_mask;
      if (dest_mask != '0) begin
        w_state_nx = BCAST;
      end else begin
        w_state_nx = IDLE;
        w_drop_nx  = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE:    w_state_nx = IDLE;
        BCAST:   if (w_retire) begin
                   w_state_nx   = IDLE;
                   w_pending_nx = '0;
                 end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign out_valid = r_pending;
  assign busy      = (r_state == BCAST);
  assign drop      = r_drop;

  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign out_data[i*WIDTH +: WIDTH] = r_hold;
  end

`ifdef FORK4_PERF_EN
  for (genvar i = 0; i < N_OUT; i++) begin : g_stall
    fork4_sat_ctr #(.CNT_W(CNT_W)) u_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (r_pending[i] & ~out_ready[i]),
      .o_cnt (stall_cnt[i*CNT_W +: CNT_W])
    );
  end

  fork4_sat_ctr #(.CNT_W(CNT_W)) u_tok (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_hs),
    .o_cnt (tok_cnt)
  );
`else
  logic [CNT_W-1:0] w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fork4_ctrl.sv
// tb_fork4_ctrl: directed and randomized checks of fork4_ctrl against a
// behavioural model (owed-destination set) and per-output delivery queues.
module tb_fork4_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  dest_mask = 4'h0;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'h0;
  logic        busy;
  logic        drop;
`ifdef FORK4_PERF_EN
  logic [63:0] stall_cnt;
  logic [15:0] tok_cnt;
`endif

  int checks = 0;
  int failures = 0;

  fork4_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dest_mask (dest_mask),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .drop      (drop)
`ifdef FORK4_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .tok_cnt   (tok_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the last accepted token, the set of destinations still owed it,
  // whether the controller has been enabled since reset, and a drop flag.
  logic [7:0] m_data = 8'h00;
  logic [3:0] m_owed = 4'h0;
  logic       m_en   = 1'b0;
  logic       m_drop = 1'b0;
  logic       exp_rdy;

  // A new token fits when every destination still owed takes its copy now.
  assign exp_rdy = m_en && ((m_owed & ~out_ready) == 4'h0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data <= 8'h00;
      m_owed <= 4'h0;
      m_en   <= 1'b0;
      m_drop <= 1'b0;
    end else begin
      m_en <= 1'b1;
      if (in_valid && exp_rdy) begin
        m_data <= in_data;
        m_owed <= dest_mask;
        m_drop <= (dest_mask == 4'h0);
      end else begin
        m_owed <= m_owed & ~out_ready;
        m_drop <= 1'b0;
      end
    end
  end

  // Per-output queues of tokens each consumer must still receive, in order.
  logic [7:0] q [4][$];

  // Every cycle: outputs vs model, then scoreboard deliveries and new tokens.
  always @(negedge clk) begin
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_owed);
    chk("busy", busy, m_owed != 4'h0);
    chk("drop", drop, m_drop);
    chk("out_data", out_data, {4{m_data}});
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (q[i].size() == 0) chk("sb_extra", 1, 0);
          else chk("sb_data", out_data[i*8 +: 8], q[i].pop_front());
        end
      end
      if (in_valid && exp_rdy)
        for (int i = 0; i < 4; i++)
          if (dest_mask[i]) q[i].push_back(in_data);
    end
  end

  initial begin
    // Reset held 3 cycles with a token offered.
    in_valid = 1'b1; dest_mask = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk); chk("en_wait", in_ready, 0);
    tick();
    @(negedge clk); chk("en_ready", in_ready, 1);

    // Full broadcast, back-to-back tokens.
    tick();
    in_valid = 1'b1; in_data = 8'hA5; dest_mask = 4'hF; out_ready = 4'hF;
    @(negedge clk); chk("bc_ready0", in_ready, 1);
    tick(); in_data = 8'h3C;
    @(negedge clk);
    chk("bc_valid1", out_valid, 4'hF);
    chk("bc_data1", out_data, 32'hA5A5A5A5);
    chk("bc_ready1", in_ready, 1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("bc_valid2", out_valid, 4'hF);
    chk("bc_data2", out_data, 32'h3C3C3C3C);
    tick();
    @(negedge clk);
    chk("bc_idle", out_valid, 0);
    chk("bc_busy", busy, 0);

    // Staggered acceptance F->E->C->C->0.
    tick(); in_valid = 1'b1; in_data = 8'h5A; dest_mask = 4'hF; out_ready = 4'h0;
    tick(); in_valid = 1'b0; out_ready = 4'b0001;
    @(negedge clk); chk("st_v1", out_valid, 4'hF); chk("st_r1", in_ready, 0);
    tick(); out_ready = 4'b0010;
    @(negedge clk); chk("st_v2", out_valid, 4'hE); chk("st_r2", in_ready, 0);
    tick(); out_ready = 4'b0000;
    @(negedge clk); chk("st_v3", out_valid, 4'hC); chk("st_r3", in_ready, 0);
    tick(); out_ready = 4'b1100;
    @(negedge clk); chk("st_v4", out_valid, 4'hC); chk("st_r4", in_ready, 1);
    tick();
    @(negedge clk); chk("st_v5", out_valid, 4'h0);

    // Partial mask, then an empty mask that drops.
    tick(); in_valid = 1'b1; in_data = 8'h12; dest_mask = 4'b0101; out_ready = 4'h0;
    tick(); in_data = 8'h77; dest_mask = 4'h0; out_ready = 4'hF;
    @(negedge clk); chk("pm_valid", out_valid, 4'b0101); chk("pm_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("dr_pulse", drop, 1);
    chk("dr_valid", out_valid, 0);
    chk("dr_busy", busy, 0);
    tick();
    @(negedge clk); chk("dr_clear", drop, 0);

    // Reset mid-broadcast with pending 1010.
    tick(); in_valid = 1'b1; in_data = 8'h99; dest_mask = 4'hF; out_ready = 4'h0;
    tick(); in_valid = 1'b0; out_ready = 4'b0101;
    tick(); out_ready = 4'h0;
    @(negedge clk); chk("mr_pending", out_valid, 4'b1010);
    #1 rst_n = 1'b0;
    #1 chk("mr_async_valid", out_valid, 0); chk("mr_async_busy", busy, 0);
    tick(); tick(); rst_n = 1'b1;
    tick(); in_valid = 1'b1; in_data = 8'h01; dest_mask = 4'hF; out_ready = 4'hF;
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("mr_valid", out_valid, 4'hF); chk("mr_data", out_data, 32'h01010101);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      tick();
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      dest_mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      out_ready = 4'($urandom);
    end
    tick(); in_valid = 1'b0; out_ready = 4'hF;
    repeat (3) tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("sb_left", q[i].size(), 0);

`ifdef FORK4_PERF_EN
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    tick(); in_valid = 1'b1; in_data = 8'h42; dest_mask = 4'hF; out_ready = 4'b0111;
    tick(); in_valid = 1'b0;
    repeat (4) tick();
    tick(); out_ready = 4'hF;
    tick();
    @(negedge clk);
    chk("pf_stall3", stall_cnt[48 +: 16], 5);
    chk("pf_stall0", stall_cnt[0 +: 16], 0);
    chk("pf_stall1", stall_cnt[16 +: 16], 0);
    chk("pf_stall2", stall_cnt[32 +: 16], 0);
    chk("pf_tok", tok_cnt, 1);
    tick(); in_valid = 1'b1; dest_mask = 4'h8; out_ready = 4'h0;
    tick(); in_valid = 1'b0;
    repeat (65539) tick();
    @(negedge clk); chk("pf_sat", stall_cnt[48 +: 16], 16'hFFFF);
    tick(); out_ready = 4'hF;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
